// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, funct3 access-mode constants and a small helper
//            for the two-port data-memory arbiter.
// Contents : port_idx_t, mem_req_t, MODE_* constants, grant_idx()
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Index of an arbiter port: 0 = instruction fetch, 1 = load/store unit.
  typedef logic port_idx_t;

  // funct3 access modes as seen by the data memory.
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_D  = 3'b011;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;
  localparam logic [2:0] MODE_WU = 3'b110;

  // Default field widths of a single memory request.
  localparam int C_MEM_BITS  = 20;
  localparam int C_DATA_SIZE = 64;

  typedef struct packed {
    logic [C_MEM_BITS-1:0]  addr;
    logic [2:0]             mode;
    logic                   we;
    logic [C_DATA_SIZE-1:0] wdata;
  } mem_req_t;

  // Converts a one-hot two-port grant into a port index. With a one-hot
  // (or empty) grant, bit 1 alone identifies the winner.
  function automatic port_idx_t grant_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-requester round-robin arbiter. A lone eligible requester
//            always wins; when both are eligible the priority pointer picks
//            the winner, and after every grant the pointer moves to the
//            other port.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset (pointer -> port 0)
//            elig  - per-port eligibility, bit i = port i
//            grant - one-hot grant, combinational from elig
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  port_idx_t r_prio;

  always_comb begin
    grant = 2'b00;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer only moves when something was actually granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (|grant) begin
      r_prio <= ~grant_idx(grant);
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port data memory (combinational read, posedge
//            write) between instruction fetch (port 0) and the load/store
//            unit (port 1). At most one access per cycle; each granted
//            access produces a registered response one cycle later, held in
//            a per-port buffer until accepted. Counts contention cycles.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/ready/we/addr/mode/wdata - per-port request channel
//            resp_valid/ready/rdata     - per-port response channel
//            mem_we/address/mode/wdata  - memory request outputs
//            mem_rdata                  - memory read data
//            conflict_cnt               - saturating contention counter
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_BITS  = 20,
  parameter int DATA_SIZE = 64,
  parameter int CNT_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*MEM_BITS-1:0]  req_addr,
  input  logic [2*3-1:0]         req_mode,
  input  logic [2*DATA_SIZE-1:0] req_wdata,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [2*DATA_SIZE-1:0] resp_rdata,
  output logic                   mem_we,
  output logic [MEM_BITS-1:0]    mem_address,
  output logic [2:0]             mem_mode,
  output logic [DATA_SIZE-1:0]   mem_wdata,
  input  logic [DATA_SIZE-1:0]   mem_rdata,
  output logic [CNT_BITS-1:0]    conflict_cnt
);

  logic [1:0]                 r_resp_valid;
  logic [1:0][DATA_SIZE-1:0]  r_rdata;
  logic [CNT_BITS-1:0]        r_conflict_cnt;

  logic [1:0]                 w_elig;
  logic [1:0]                 w_grant;
  logic                       w_any;
  port_idx_t                  w_gidx;

  // A port may only be granted if its response slot is free or is being
  // emptied this very cycle. Gating with rst_n suppresses every access
  // (including memory writes) while reset is asserted.
  assign w_elig = req_valid & (~r_resp_valid | resp_ready) & {2{rst_n}};

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .elig  (w_elig),
    .grant (w_grant)
  );

  assign w_any     = |w_grant;
  assign w_gidx    = grant_idx(w_grant);
  assign req_ready = w_grant;

  // Memory outputs are forced to zero when idle so the memory sees no
  // spurious write and a quiet bus.
  always_comb begin
    mem_we      = 1'b0;
    mem_address = '0;
    mem_mode    = 3'b000;
    mem_wdata   = '0;
    if (w_any) begin
      if (w_gidx) begin
        mem_we      = req_we[1];
        mem_address = req_addr[2*MEM_BITS-1:MEM_BITS];
        mem_mode    = req_mode[5:3];
        mem_wdata   = req_wdata[2*DATA_SIZE-1:DATA_SIZE];
      end else begin
        mem_we      = req_we[0];
        mem_address = req_addr[MEM_BITS-1:0];
        mem_mode    = req_mode[2:0];
        mem_wdata   = req_wdata[DATA_SIZE-1:0];
      end
    end
  end

  // Response buffers: a grant (re)loads the slot, which is legal because a
  // granted port's slot is either empty or popped in the same cycle.
  // Writes return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 2'b00;
      r_rdata      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_resp_valid[i] <= 1'b1;
          r_rdata[i]      <= req_we[i] ? '0 : mem_rdata;
        end else if (resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Contention is measured on raw request demand, independent of whether
  // a blocked response makes one port ineligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if ((req_valid == 2'b11) && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_rdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a behavioural
//            funct3 data memory attached to the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MB = 20;
  localparam int DS = 64;
  localparam int CB = 32;

  localparam logic [DS-1:0] A1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DS-1:0] A2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [DS-1:0] WD = 64'hDEAD_BEEF_0123_4567;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [2*MB-1:0]    req_addr;
  logic [5:0]         req_mode;
  logic [2*DS-1:0]    req_wdata;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [2*DS-1:0]    resp_rdata;
  logic               mem_we;
  logic [MB-1:0]      mem_address;
  logic [2:0]         mem_mode;
  logic [DS-1:0]      mem_wdata;
  logic [DS-1:0]      mem_rdata;
  logic [CB-1:0]      conflict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BITS(MB), .DATA_SIZE(DS), .CNT_BITS(CB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_mode     (req_mode),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_mode     (mem_mode),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  // ---------------- behavioural data memory (32 words) --------------------
  logic [DS-1:0] mem [0:31];
  logic [DS-1:0] word;

  always_comb begin
    word = (mem_address[MB-1:5] == '0) ? mem[mem_address[4:0]] : '0;
    case (mem_mode)
      3'b000:  mem_rdata = {{56{word[7]}},  word[7:0]};
      3'b001:  mem_rdata = {{48{word[15]}}, word[15:0]};
      3'b010:  mem_rdata = {{32{word[31]}}, word[31:0]};
      3'b100:  mem_rdata = {56'd0, word[7:0]};
      3'b101:  mem_rdata = {48'd0, word[15:0]};
      3'b110:  mem_rdata = {32'd0, word[31:0]};
      default: mem_rdata = word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_mode)
        3'b000, 3'b100: mem[mem_address[4:0]][7:0]  <= mem_wdata[7:0];
        3'b001, 3'b101: mem[mem_address[4:0]][15:0] <= mem_wdata[15:0];
        3'b010, 3'b110: mem[mem_address[4:0]][31:0] <= mem_wdata[31:0];
        default:        mem[mem_address[4:0]]       <= mem_wdata;
      endcase
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic clr_req();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_mode  = '0;
    req_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [MB-1:0] a,
                          input logic [2:0] m, input logic [DS-1:0] d);
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*MB +: MB]  = a;
    req_mode[p*3 +: 3]    = m;
    req_wdata[p*DS +: DS] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    clr_req();
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Writes a full dword through port 1 and drains its response.
  task automatic preload(input logic [MB-1:0] a, input logic [DS-1:0] d);
    clr_req();
    resp_ready = 2'b11;
    set_port(1, 1'b1, a, MODE_D, d);
    step();
    clr_req();
    step();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst_n      = 1'b0;
    resp_ready = 2'b00;
    clr_req();
    set_port(0, 1'b1, 20'd1, MODE_D, 64'h1);
    set_port(1, 1'b1, 20'd2, MODE_D, 64'h2);
    #2;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_we got=%b exp=0", mem_we);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_req();
    resp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_outputs req_ready=%b mem_we=%b exp=00/0", req_ready, mem_we);
    end
    checks++;
    if (resp_valid !== 2'b00 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL reset_resp valid=%b rdata=%h exp=00/0", resp_valid, resp_rdata);
    end
    checks++;
    if (conflict_cnt !== '0) begin
      failures++;
      $display("FAIL reset_conflict got=%0d exp=0", conflict_cnt);
    end
    checks++;
    if (mem_address !== '0 || mem_mode !== 3'b000 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL idle_mem_bus addr=%h mode=%b wdata=%h exp=0", mem_address, mem_mode, mem_wdata);
    end
    step();
  endtask

  task automatic test_write_then_read();
    clr_req();
    resp_ready = 2'b11;
    set_port(1, 1'b1, 20'd5, MODE_D, WD);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || mem_we !== 1'b1 || mem_address !== 20'd5 ||
        mem_mode !== 3'b011 || mem_wdata !== WD) begin
      failures++;
      $display("FAIL wr_drive ready=%b we=%b addr=%h mode=%b wdata=%h exp=10/1/5/011/%h",
               req_ready, mem_we, mem_address, mem_mode, mem_wdata, WD);
    end
    step();
    checks++;
    if (resp_valid !== 2'b10 || resp_rdata[DS +: DS] !== '0) begin
      failures++;
      $display("FAIL wr_resp valid=%b rdata1=%h exp=10/0", resp_valid, resp_rdata[DS +: DS]);
    end
    clr_req();
    set_port(0, 1'b0, 20'd5, MODE_D, '0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01 || mem_we !== 1'b0 || mem_address !== 20'd5) begin
      failures++;
      $display("FAIL rd_drive ready=%b we=%b addr=%h exp=01/0/5", req_ready, mem_we, mem_address);
    end
    step();
    checks++;
    if (resp_valid !== 2'b01 || resp_rdata[0 +: DS] !== WD) begin
      failures++;
      $display("FAIL rd_after_wr valid=%b rdata0=%h exp=01/%h", resp_valid, resp_rdata[0 +: DS], WD);
    end
    clr_req();
    step();
    checks++;
    if (resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL resp_drain got=%b exp=00", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g;
    logic [MB-1:0] exp_a;
    logic [DS-1:0] exp_d;
    preload(20'd1, A1);
    preload(20'd2, A2);
    do_reset();
    resp_ready = 2'b11;
    set_port(0, 1'b0, 20'd1, MODE_D, '0);
    set_port(1, 1'b0, 20'd2, MODE_D, '0);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 20'd1 : 20'd2;
      exp_d = (k % 2 == 0) ? A1 : A2;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g || mem_address !== exp_a) begin
        failures++;
        $display("FAIL rr_grant k=%0d ready=%b addr=%h exp=%b/%h", k, req_ready, mem_address, exp_g, exp_a);
      end
      step();
      checks++;
      if (resp_valid !== exp_g || resp_rdata[(k % 2)*DS +: DS] !== exp_d) begin
        failures++;
        $display("FAIL rr_resp k=%0d valid=%b rdata=%h exp=%b/%h", k, resp_valid,
                 resp_rdata[(k % 2)*DS +: DS], exp_g, exp_d);
      end
    end
    checks++;
    if (conflict_cnt !== 32'd4) begin
      failures++;
      $display("FAIL rr_conflict got=%0d exp=4", conflict_cnt);
    end
    clr_req();
    step();
  endtask

  task automatic test_blocked_port();
    do_reset();
    resp_ready = 2'b00;
    set_port(0, 1'b0, 20'd1, MODE_D, '0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL blk_first got=%b exp=01", req_ready);
    end
    step();
    set_port(1, 1'b0, 20'd2, MODE_D, '0);
    resp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
        failures++;
        $display("FAIL blk_grant k=%0d got=%b exp=10", k, req_ready);
      end
      step();
      checks++;
      if (resp_valid !== 2'b11 || resp_rdata[0 +: DS] !== A1 || resp_rdata[DS +: DS] !== A2) begin
        failures++;
        $display("FAIL blk_hold k=%0d valid=%b rdata=%h exp=11/%h%h", k, resp_valid, resp_rdata, A2, A1);
      end
    end
    resp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL blk_release got=%b exp=01", req_ready);
    end
    step();
    checks++;
    if (resp_valid !== 2'b01 || resp_rdata[0 +: DS] !== A1) begin
      failures++;
      $display("FAIL blk_reload valid=%b rdata0=%h exp=01/%h", resp_valid, resp_rdata[0 +: DS], A1);
    end
    clr_req();
    step();
  endtask

  task automatic test_modes();
    preload(20'd3, 64'h0000_0000_0000_00FF);
    resp_ready = 2'b11;
    set_port(0, 1'b0, 20'd3, MODE_B, '0);
    step();
    checks++;
    if (resp_rdata[0 +: DS] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++;
      $display("FAIL mode_b got=%h exp=ffffffffffffffff", resp_rdata[0 +: DS]);
    end
    set_port(0, 1'b0, 20'd3, MODE_BU, '0);
    step();
    checks++;
    if (resp_rdata[0 +: DS] !== 64'h0000_0000_0000_00FF) begin
      failures++;
      $display("FAIL mode_bu got=%h exp=00000000000000ff", resp_rdata[0 +: DS]);
    end
    set_port(0, 1'b0, 20'd3, 3'b111, '0);
    @(negedge clk);
    checks++;
    if (mem_mode !== 3'b111) begin
      failures++;
      $display("FAIL mode_passthru got=%b exp=111", mem_mode);
    end
    step();
    clr_req();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_ready = 2'b00;
    set_port(1, 1'b0, 20'd2, MODE_D, '0);
    step();
    set_port(0, 1'b0, 20'd1, MODE_D, '0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=01", req_ready);
    end
    step();
    checks++;
    if (resp_valid !== 2'b11) begin
      failures++;
      $display("FAIL mid_both_valid got=%b exp=11", resp_valid);
    end
    req_we     = 2'b11;
    resp_ready = 2'b11;
    rst_n      = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 2'b00 || resp_rdata !== '0 || req_ready !== 2'b00 ||
        mem_we !== 1'b0 || conflict_cnt !== '0) begin
      failures++;
      $display("FAIL mid_reset valid=%b rdata=%h ready=%b we=%b cnt=%0d exp=00/0/00/0/0",
               resp_valid, resp_rdata, req_ready, mem_we, conflict_cnt);
    end
    step();
    rst_n  = 1'b1;
    req_we = 2'b00;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_prio got=%b exp=01", req_ready);
    end
    step();
    clr_req();
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    resp_ready = 2'b00;
    clr_req();
    test_reset();
    test_write_then_read();
    test_round_robin();
    test_blocked_port();
    test_modes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
